// File: rtl/serial_memory_probe_pkg.sv
// serial_memory_probe_pkg: shared types for the bit-serial memory probe.
// FSM state enum, opcode constants, counter width helper.
package serial_memory_probe_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_IN,
    ACCESS,
    SHIFT_OUT
  } state_e;

  localparam logic OP_READ_MEM = 1'b0;
  localparam logic OP_READ_IP  = 1'b1;

  // Width of a counter indexing n items (0..n-1), at least 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_memory_probe_if.sv
// serial_memory_probe_if: host-side serial link, write port and ip status.
// master = host (drives sin/mem_*), slave = probe (drives sout/ready/ip).
interface serial_memory_probe_if #(
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 8,
  parameter int IP_BITS   = 5
);

  logic                 sin;
  logic                 sin_valid;
  logic                 sin_ready;
  logic                 sout;
  logic                 sout_valid;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic [IP_BITS-1:0]   ip;
  logic                 ip_step;

  modport master (
    output sin, sin_valid,
    output mem_we, mem_waddr, mem_wdata,
    input  sin_ready, sout, sout_valid,
    input  ip, ip_step
  );

  modport slave (
    input  sin, sin_valid,
    input  mem_we, mem_waddr, mem_wdata,
    output sin_ready, sout, sout_valid,
    output ip, ip_step
  );

endinterface

// File: rtl/serial_memory_probe_mem.sv
// probe_mem: 2**AW x DW memory, sync write, async read, write-first bypass.
// Ports: clk_i, we_i, waddr_i, wdata_i, raddr_i -> rdata_o.
import serial_memory_probe_pkg::*;

module probe_mem #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // A same-cycle write to the read address wins over the stored word.
  assign rdata_o = (we_i && (waddr_i == raddr_i))
                 ? wdata_i : mem_q[raddr_i];

endmodule

// File: rtl/serial_memory_probe.sv
// serial_memory_probe: bit-serial debug port reading memory or the ip.
// Ports: clock, reset, bus (slave: sin/sout handshakes, host write, ip).
import serial_memory_probe_pkg::*;

module serial_memory_probe #(
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 8,
  parameter int IP_BITS   = 5
) (
  input logic clock,
  input logic reset,
  serial_memory_probe_if.slave bus
);

  localparam int ACW = cnt_w(ADDR_BITS);
  localparam int DCW = cnt_w(DATA_BITS);
  localparam int IPW = (IP_BITS < DATA_BITS)
                     ? IP_BITS : DATA_BITS;

  state_e               state_q;
  logic                 op_q;
  logic [ACW-1:0]       acnt_q;
  logic [DCW-1:0]       dcnt_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] resp_q;
  logic [DATA_BITS-1:0] resp_d;
  logic [DATA_BITS-1:0] rdata;
  logic [DATA_BITS-1:0] ip_ext;
  logic [IP_BITS-1:0]   ip_q;
  logic                 sin_ready_q;
  logic                 sout_q;
  logic                 sout_valid_q;
  logic                 take;

  probe_mem #(
    .AW (ADDR_BITS),
    .DW (DATA_BITS)
  ) u_mem (
    .clk_i   (clock),
    .we_i    (bus.mem_we),
    .waddr_i (bus.mem_waddr),
    .wdata_i (bus.mem_wdata),
    .raddr_i (addr_q),
    .rdata_o (rdata)
  );

  assign take = bus.sin_valid & sin_ready_q;

  // ip is zero-extended or truncated to the response width.
  always_comb begin
    ip_ext = '0;
    ip_ext[IPW-1:0] = ip_q[IPW-1:0];
    resp_d = (op_q == OP_READ_IP) ? ip_ext : rdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= OP_READ_MEM;
      acnt_q       <= '0;
      dcnt_q       <= '0;
      addr_q       <= '0;
      resp_q       <= '0;
      ip_q         <= '0;
      sin_ready_q  <= 1'b1;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (take) begin
            op_q    <= bus.sin;
            acnt_q  <= '0;
            state_q <= SHIFT_IN;
          end
        end
        SHIFT_IN: begin
          if (take) begin
            addr_q[acnt_q] <= bus.sin;
            if (acnt_q == ACW'(ADDR_BITS-1)) begin
              state_q     <= ACCESS;
              sin_ready_q <= 1'b0;
            end else begin
              acnt_q <= acnt_q + 1'b1;
            end
          end
        end
        ACCESS: begin
          // sout carries bit 0 as soon as SHIFT_OUT starts.
          resp_q       <= resp_d;
          sout_q       <= resp_d[0];
          sout_valid_q <= 1'b1;
          dcnt_q       <= '0;
          ip_q         <= ip_q + 1'b1;
          state_q      <= SHIFT_OUT;
        end
        SHIFT_OUT: begin
          if (dcnt_q == DCW'(DATA_BITS-1)) begin
            state_q      <= IDLE;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            sin_ready_q  <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
            resp_q <= resp_q >> 1;
            sout_q <= resp_q[1];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sin_ready  = sin_ready_q;
  assign bus.sout       = sout_q;
  assign bus.sout_valid = sout_valid_q;
  assign bus.ip         = ip_q;
  assign bus.ip_step    = (state_q == ACCESS);

endmodule

// File: tb/tb_serial_memory_probe.sv
// tb_serial_memory_probe: vector table + scoreboard bench for the probe.
// Drives serial frames, collects serial responses, compares per word.
module tb_serial_memory_probe;

  localparam int AB = 4;
  localparam int DB = 8;
  localparam int IB = 5;

  typedef struct {
    logic          op;
    logic [AB-1:0] addr;
    int            gap;
    logic [DB-1:0] exp;
  } vec_t;

  logic clock;
  logic reset;

  serial_memory_probe_if #(
    .ADDR_BITS (AB),
    .DATA_BITS (DB),
    .IP_BITS   (IB)
  ) bus ();

  serial_memory_probe #(
    .ADDR_BITS (AB),
    .DATA_BITS (DB),
    .IP_BITS   (IB)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int            n_checks = 0;
  int            n_pass   = 0;
  int            cyc      = 0;
  int            last_acc = 0;
  logic [DB-1:0] exp_q [$];
  vec_t          tbl [6];

  logic [IB-1:0] mdl_ip;
  logic [DB-1:0] word;
  int            nbits;
  int            steps;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endfunction

  // Response monitor / scoreboard consumer.
  always @(negedge clock) begin
    if (reset) begin
      mdl_ip = '0;
      nbits  = 0;
      steps  = 0;
    end else begin
      if (bus.ip_step) begin
        chk("ip_at_step", 32'(bus.ip), 32'(mdl_ip));
        mdl_ip = mdl_ip + 1'b1;
        steps++;
      end
      if (bus.sout_valid) begin
        chk("ready_low_out", 32'(bus.sin_ready), 32'd0);
        if (nbits == 0)
          chk("latency", cyc, last_acc + 2);
        word[nbits] = bus.sout;
        nbits++;
        if (nbits == DB) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL resp: got %0h want none", word);
          end else begin
            chk("resp", 32'(word), 32'(exp_q.pop_front()));
          end
          chk("ip_steps", steps, 1);
          steps = 0;
          nbits = 0;
        end
      end else begin
        chk("sout_idle", 32'(bus.sout), 32'd0);
        if (nbits != 0) begin
          n_checks++;
          $display("FAIL burst_len: got %0d want %0d", nbits, DB);
          nbits = 0;
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    int t;
    t = 0;
    @(negedge clock);
    bus.sin       = b;
    bus.sin_valid = 1'b1;
    while (!bus.sin_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (t >= 200) begin
      n_checks++;
      $display("FAIL accept_timeout: got ready=0 want 1");
    end
    last_acc = cyc;
    @(posedge clock);
    #1;
    bus.sin_valid = 1'b0;
  endtask

  task automatic send_frame(input logic          op,
                            input logic [AB-1:0] addr,
                            input int            gap,
                            input logic [DB-1:0] exp,
                            input bit            hold,
                            input bit            byp,
                            input logic [DB-1:0] bdata);
    int t;
    send_bit(op);
    for (int i = 0; i < AB; i++) begin
      repeat (gap) @(negedge clock);
      send_bit(addr[i]);
    end
    exp_q.push_back(exp);
    if (byp) begin
      bus.mem_we    = 1'b1;
      bus.mem_waddr = addr;
      bus.mem_wdata = bdata;
      @(posedge clock);
      #1;
      bus.mem_we = 1'b0;
    end
    if (hold) begin
      t = 0;
      while (t < 100) begin
        @(negedge clock);
        if (bus.sin_ready) break;
        bus.sin       = 1'b1;
        bus.sin_valid = 1'b1;
        t++;
      end
      bus.sin_valid = 1'b0;
    end
  endtask

  task automatic host_write(input logic [AB-1:0] a,
                            input logic [DB-1:0] d);
    @(negedge clock);
    bus.mem_we    = 1'b1;
    bus.mem_waddr = a;
    bus.mem_wdata = d;
    @(negedge clock);
    bus.mem_we = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.sout_valid) && t < 500) begin
      @(negedge clock);
      t++;
    end
    if (t >= 500) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d pending want 0",
               exp_q.size());
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset         = 1'b1;
    bus.sin_valid = 1'b0;
    bus.mem_we    = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.sin       = 1'b0;
    bus.sin_valid = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_waddr = '0;
    bus.mem_wdata = '0;

    tbl[0] = '{1'b0, 4'd10, 0, 8'h5A};
    tbl[1] = '{1'b0, 4'd10, 3, 8'h5A};
    tbl[2] = '{1'b0, 4'd10, 7, 8'h5A};
    tbl[3] = '{1'b0, 4'd3,  3, 8'hC3};
    tbl[4] = '{1'b1, 4'd9,  7, 8'h07};
    tbl[5] = '{1'b0, 4'd5,  0, 8'hA5};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_ready", 32'(bus.sin_ready), 32'd1);
    chk("rst_sout_valid", 32'(bus.sout_valid), 32'd0);
    chk("rst_sout", 32'(bus.sout), 32'd0);
    chk("rst_ip", 32'(bus.ip), 32'd0);
    chk("rst_ip_step", 32'(bus.ip_step), 32'd0);

    // Single READ_MEM of a host-written word.
    host_write(4'd5, 8'hA5);
    send_frame(1'b0, 4'd5, 0, 8'hA5, 0, 0, '0);
    wait_idle();
    chk("ip_after_mem", 32'(bus.ip), 32'd1);

    // Back-to-back READ_IP frames.
    do_reset();
    send_frame(1'b1, 4'd0, 0, 8'h00, 0, 0, '0);
    send_frame(1'b1, 4'd6, 0, 8'h01, 0, 0, '0);
    send_frame(1'b1, 4'd15, 0, 8'h02, 0, 0, '0);
    wait_idle();
    chk("ip_after_3ip", 32'(bus.ip), 32'd3);

    // Table: gaps between request bits.
    host_write(4'd10, 8'h5A);
    host_write(4'd3, 8'hC3);
    for (int i = 0; i < 6; i++)
      send_frame(tbl[i].op, tbl[i].addr, tbl[i].gap,
                 tbl[i].exp, 0, 0, '0);
    wait_idle();
    chk("ip_after_tbl", 32'(bus.ip), 32'd9);

    // Request bits offered during SHIFT_OUT are dropped.
    send_frame(1'b0, 4'd3, 0, 8'hC3, 1, 0, '0);
    send_frame(1'b0, 4'd5, 0, 8'hA5, 0, 0, '0);
    wait_idle();
    chk("ip_after_hold", 32'(bus.ip), 32'd11);

    // ip wrap over 32 READ_IP frames.
    do_reset();
    for (int i = 0; i < 32; i++)
      send_frame(1'b1, 4'(i), 0, 8'(i), 0, 0, '0);
    wait_idle();
    chk("ip_wrap", 32'(bus.ip), 32'd0);

    // Reset on the 2nd address bit discards the frame.
    send_frame(1'b1, 4'd1, 0, 8'h00, 0, 0, '0);
    wait_idle();
    chk("ip_pre_abort", 32'(bus.ip), 32'd1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clock);
    bus.sin       = 1'b0;
    bus.sin_valid = 1'b1;
    reset         = 1'b1;
    @(negedge clock);
    bus.sin_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_ip", 32'(bus.ip), 32'd0);
    chk("abort_ready", 32'(bus.sin_ready), 32'd1);
    chk("abort_sout_valid", 32'(bus.sout_valid), 32'd0);
    send_frame(1'b1, 4'd2, 0, 8'h00, 0, 0, '0);
    wait_idle();

    // Write-first bypass in the ACCESS cycle.
    host_write(4'd7, 8'h11);
    send_frame(1'b0, 4'd7, 0, 8'h3C, 0, 1, 8'h3C);
    send_frame(1'b0, 4'd7, 2, 8'h3C, 0, 0, '0);
    wait_idle();
    chk("ip_end", 32'(bus.ip), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
